// File: rtl/cam_pixel_packer.sv
// cam_pixel_packer
//   Converts an 8-bit DVP-style camera stream (pclk/href/vsync/data, all
//   treated as data and sampled on clk) into 16-bit pixel words tagged with
//   their x/y position. It also reports frame/line strobes, a sticky
//   line-geometry error and a free-running frame counter.
//
//   Optional feature macro: CAM_SYNC_EN
//     defined   : 2-flop input synchronizer, edges acted on 3 clk after input change
//     undefined : 1 register stage, edges acted on 2 clk after input change
//
// Parameters
//   H_WORDS     words per line (2 bytes each)
//   V_LINES     lines per frame
// Ports
//   clk         system clock (only clock)
//   rst         synchronous active-high reset
//   cam_pclk    camera pixel clock, at most clk/4, sampled as data
//   cam_href    line valid
//   cam_vsync   frame sync, high = vertical blank
//   cam_d       camera data byte
//   word_out    packed word, first byte of the pair in [15:8]
//   word_valid  one-clk strobe for word_out
//   pix_x       word index of word_out within the line
//   pix_y       line index within the frame
//   frame_start one-clk strobe at frame start
//   line_done   one-clk strobe at end of an in-range line
//   err_line    sticky line length / line count error, cleared at frame start
//   frame_count frames started, wraps at 8 bits
module cam_pixel_packer #(
  parameter int H_WORDS = 320,
  parameter int V_LINES = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_pclk,
  input  logic        cam_href,
  input  logic        cam_vsync,
  input  logic [7:0]  cam_d,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic        line_done,
  output logic        err_line,
  output logic [7:0]  frame_count
);

  localparam int IW = 11;
  localparam logic [9:0]  H_LIM = 10'(H_WORDS);
  localparam logic [9:0]  V_LIM = 10'(V_LINES);
  localparam logic [11:0] B_LIM = 12'(2 * H_WORDS);

  typedef enum logic [1:0] {IDLE, VBLANK, FRAME, LINE} state_t;

  // ---------------------------------------------------------------------
  // Input stage: all camera signals travel together so data stays aligned
  // with the pclk edge that qualifies it.
  // ---------------------------------------------------------------------
  logic [IW-1:0] in_raw, in_s;
  assign in_raw = {cam_pclk, cam_href, cam_vsync, cam_d};

`ifdef CAM_SYNC_EN
  logic [IW-1:0] in_meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      in_meta <= '0;
      in_s    <= '0;
    end else begin
      in_meta <= in_raw;
      in_s    <= in_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) in_s <= '0;
    else     in_s <= in_raw;
  end
`endif

  logic       pclk_s, href_s, vsync_s;
  logic [7:0] d_s;
  assign {pclk_s, href_s, vsync_s, d_s} = in_s;

  logic pclk_q, href_q, vsync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q  <= 1'b0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      pclk_q  <= pclk_s;
      href_q  <= href_s;
      vsync_q <= vsync_s;
    end
  end

  logic pclk_rise, href_rise, href_fall, vsync_rise, vsync_fall;
  assign pclk_rise  =  pclk_s  & ~pclk_q;
  assign href_rise  =  href_s  & ~href_q;
  assign href_fall  = ~href_s  &  href_q;
  assign vsync_rise =  vsync_s & ~vsync_q;
  assign vsync_fall = ~vsync_s &  vsync_q;

  // ---------------------------------------------------------------------
  // Packer FSM
  // ---------------------------------------------------------------------
  state_t      state, state_n;
  logic        phase, phase_n;      // 0: next byte is the high byte
  logic [7:0]  hi_byte, hi_byte_n;
  logic [11:0] bcnt, bcnt_n;        // bytes seen this line, saturating
  logic        line_ok, line_ok_n;  // line index within V_LINES

  logic [15:0] word_out_n;
  logic        word_valid_n, frame_start_n, line_done_n, err_line_n;
  logic [9:0]  pix_x_n;
  logic [8:0]  pix_y_n;
  logic [7:0]  frame_count_n;

  // pix_y advances the cycle after line_done; a line starting right then
  // must see the advanced index.
  logic [9:0] y_cur;
  assign y_cur = {1'b0, pix_y} + {9'd0, line_done};

  always_comb begin
    state_n       = state;
    phase_n       = phase;
    hi_byte_n     = hi_byte;
    bcnt_n        = bcnt;
    line_ok_n     = line_ok;
    word_out_n    = word_out;
    word_valid_n  = 1'b0;
    frame_start_n = 1'b0;
    line_done_n   = 1'b0;
    err_line_n    = err_line;
    frame_count_n = frame_count;
    // Position counters step one cycle after the strobe they describe.
    pix_x_n       = word_valid ? pix_x + 10'd1 : pix_x;
    pix_y_n       = line_done  ? pix_y + 9'd1  : pix_y;

    case (state)
      IDLE: begin
        if (vsync_s) state_n = VBLANK;
      end
      VBLANK: begin
        if (vsync_fall) begin
          state_n       = FRAME;
          frame_start_n = 1'b1;
          pix_y_n       = '0;
          err_line_n    = 1'b0;
          frame_count_n = frame_count + 8'd1;
        end
      end
      FRAME: begin
        if (vsync_rise) begin
          state_n = VBLANK;
        end else if (href_rise) begin
          state_n   = LINE;
          pix_x_n   = '0;
          phase_n   = 1'b0;
          bcnt_n    = '0;
          line_ok_n = (y_cur < V_LIM);
          if (y_cur >= V_LIM) err_line_n = 1'b1;
        end
      end
      LINE: begin
        if (vsync_rise) begin
          state_n = VBLANK;
          phase_n = 1'b0;
        end else if (href_fall) begin
          state_n = FRAME;
          phase_n = 1'b0;
          if (line_ok) line_done_n = 1'b1;
          // odd byte count is covered by the length mismatch too
          if (phase || bcnt != B_LIM) err_line_n = 1'b1;
        end else if (pclk_rise) begin
          if (bcnt != 12'hfff) bcnt_n = bcnt + 12'd1;
          if (!phase) begin
            hi_byte_n = d_s;
            phase_n   = 1'b1;
          end else begin
            phase_n      = 1'b0;
            word_out_n   = {hi_byte, d_s};
            word_valid_n = line_ok && (pix_x < H_LIM);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= 1'b0;
      hi_byte     <= '0;
      bcnt        <= '0;
      line_ok     <= 1'b0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_done   <= 1'b0;
      err_line    <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      hi_byte     <= hi_byte_n;
      bcnt        <= bcnt_n;
      line_ok     <= line_ok_n;
      word_out    <= word_out_n;
      word_valid  <= word_valid_n;
      pix_x       <= pix_x_n;
      pix_y       <= pix_y_n;
      frame_start <= frame_start_n;
      line_done   <= line_done_n;
      err_line    <= err_line_n;
      frame_count <= frame_count_n;
    end
  end

endmodule
